multiplier_control: RTL and testbench
=====================================

MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the multiplier operand width in bits (N >= 2).
REQ-002 Clk  input  1  the only clock; all state SHALL change on its rising edge.
REQ-003 Reset_n  input  1  synchronous active-low reset, sampled on the Clk rising edge.
REQ-004 Run  input  1  start request, level; a multiplication SHALL start only on a 0-to-1 transition.
REQ-005 Load_Clear  input  1  level request to load operand B from switches and clear X/A.
REQ-006 M  input  1  current multiplier LSB (B[0]) from the datapath shift register.
REQ-007 Ld_B  output  1  load B register this cycle.
REQ-008 Clr_XA  output  1  clear X flip-flop and A register this cycle.
REQ-009 Add_En  output  1  load X:A with sign-extended A + S this cycle.
REQ-010 Sub_En  output  1  load X:A with sign-extended A - S this cycle.
REQ-011 Shift_En  output  1  arithmetic right shift of X:A:B by one this cycle.
REQ-012 Busy  output  1  high from the CLR cycle through the last SHIFT cycle.
REQ-013 Done  output  1  single-cycle pulse in the first HOLD cycle.

Function
REQ-014 States SHALL be IDLE, CLR, ADD, SHIFT, HOLD, with a bit counter k of ceil(log2 N) bits.
REQ-015 Run edge detection SHALL use a registered copy Run_q; rise = Run & ~Run_q.
REQ-016 IDLE: on rise, next state CLR with k=0; otherwise remain IDLE.
REQ-017 IDLE with Load_Clear=1 and no rise: Ld_B=1 and Clr_XA=1 that cycle; rise SHALL take priority over Load_Clear.
REQ-018 CLR (one cycle): Clr_XA=1, Ld_B=0; next state ADD.
REQ-019 ADD for k < N-1: Add_En = M, Sub_En = 0; for k = N-1: Sub_En = M, Add_En = 0; next state SHIFT.
REQ-020 SHIFT: Shift_En=1; if k = N-1 then next state HOLD, else k <= k+1 and next state ADD.
REQ-021 Total busy duration SHALL be exactly 2N+1 cycles (CLR + N x (ADD,SHIFT)), independent of operand values.
REQ-022 HOLD: Done=1 on first cycle only; remain in HOLD while Run=1; go to IDLE when Run=0.
REQ-023 HOLD with Load_Clear=1 SHALL assert Ld_B and Clr_XA, as in IDLE.
REQ-024 Load_Clear and Run transitions SHALL be ignored during CLR, ADD, SHIFT (no restart, no load).
REQ-025 Run held high across the end of an operation SHALL NOT start a second operation.
REQ-026 At most one of Add_En, Sub_En, Shift_En SHALL be high in any cycle; Ld_B never coincides with Add_En, Sub_En or Shift_En.
REQ-027 Add_En and Sub_En SHALL be combinational on M and state only; all other outputs are decoded from state alone.

Reset
REQ-028 Reset_n=0 at a rising edge SHALL force state IDLE, k=0, Run_q=1; this holds from any state, including mid-operation.
REQ-029 During and after reset, until the next state change, all outputs SHALL be 0.
REQ-030 Run_q reset to 1 SHALL prevent a start when Run is already high as reset releases.

Verification
REQ-031 Run held 0, then driven 1 for 25 cycles, N=8, M pattern 1,1,1,0,0,0,0,0 (B=7) -> Busy for exactly 17 cycles, Add_En high in ADD k=0,1,2 only, Sub_En never, 8 Shift_En pulses, one Done.
REQ-032 M=1 every ADD (B=-1) -> Add_En high at k=0..6, Sub_En high at k=7, Add_En low at k=7.
REQ-033 Load_Clear=1 during ADD k=3 -> no Ld_B and no Clr_XA; sequence completes unchanged.
REQ-034 Run held 1 through HOLD for 10 cycles, then 0, then 1 -> exactly two operations; no start while held.
REQ-035 Reset_n=0 for one cycle at SHIFT k=4 -> next cycle IDLE, all outputs 0; Run still high -> no restart until Run falls and rises.
REQ-036 Closed loop with a shift-add datapath model, 100 random signed 8-bit pairs -> 16-bit X:A:B product equals A*B in every case.

Source files
------------

// File: rtl/multiplier_control_if.sv
// multiplier_control_if
// Bundles the signals between the shift-add multiplier controller and its
// surroundings (operator inputs, datapath control strobes, status, debug).
//
// Signals:
//   Run        start request (level). The controller acts only on its
//              0-to-1 edge while idle.
//   Load_Clear level request to load B from switches and clear X/A.
//   M          current multiplier LSB (B[0]) from the datapath.
//   Ld_B, Clr_XA, Add_En, Sub_En, Shift_En  one-cycle datapath strobes.
//   Busy       high from the clear cycle through the last shift cycle.
//   Done       one-cycle pulse on entry to the hold state.
//   dbg_state, dbg_k  controller state and bit counter, for observation only.
//
// Handshake: there is no valid/ready pair. A request is Run rising while the
// controller is idle. Busy high means every Run/Load_Clear change is
// ignored. Done pulses once when the product is ready. The controller then
// waits in HOLD until Run is released, and only a fresh rising edge starts
// the next operation.
interface multiplier_control_if #(
  parameter int N = 8
);
  localparam int KW = $clog2(N);

  logic          Run;
  logic          Load_Clear;
  logic          M;
  logic          Ld_B;
  logic          Clr_XA;
  logic          Add_En;
  logic          Sub_En;
  logic          Shift_En;
  logic          Busy;
  logic          Done;
  logic [2:0]    dbg_state;
  logic [KW-1:0] dbg_k;

  modport master (
    output Run, Load_Clear, M,
    input  Ld_B, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done,
    input  dbg_state, dbg_k
  );

  modport slave (
    input  Run, Load_Clear, M,
    output Ld_B, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done,
    output dbg_state, dbg_k
  );
endinterface

// File: rtl/multiplier_control.sv
// multiplier_control
// Control FSM for an N-bit signed shift-add multiplier (X:A:B datapath).
// A Run rising edge starts the sequence CLR, then N x (ADD, SHIFT), then HOLD.
// In the final ADD the multiplier sign bit carries negative weight, so that
// step subtracts instead of adding.
//
// Ports:
//   Clk      rising-edge clock
//   Reset_n  synchronous active-low reset
//   bus      multiplier_control_if.slave (inputs Run/Load_Clear/M, datapath
//            strobes, Busy/Done status, debug state and counter)
module multiplier_control #(
  parameter int N = 8
) (
  input logic                  Clk,
  input logic                  Reset_n,
  multiplier_control_if.slave  bus
);
  localparam int KW = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          run_q;
  // Set only for the first HOLD cycle, so Done is a single pulse.
  logic          first_q, first_d;

  logic rise;
  logic last_k;
  logic load;

  assign rise   = bus.Run & ~run_q;
  assign last_k = (k_q == KW'(N - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_CLR;
          k_d     = '0;
        end
      end
      S_CLR:   state_d = S_ADD;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (last_k) begin
          state_d = S_HOLD;
          first_d = 1'b1;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_ADD;
        end
      end
      S_HOLD: begin
        if (!bus.Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces Run_q high so that a Run already high at release is not
  // taken as a start.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      run_q   <= 1'b1;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      run_q   <= bus.Run;
      first_q <= first_d;
    end
  end

  // Operand load is honoured only when the datapath is not in use. In IDLE a
  // start edge wins over a load request.
  assign load = bus.Load_Clear &
                (((state_q == S_IDLE) & ~rise) | (state_q == S_HOLD));

  // Every output is held low while reset is asserted, even mid-operation.
  assign bus.Ld_B     = Reset_n & load;
  assign bus.Clr_XA   = Reset_n & (load | (state_q == S_CLR));
  assign bus.Add_En   = Reset_n & (state_q == S_ADD) & bus.M & ~last_k;
  assign bus.Sub_En   = Reset_n & (state_q == S_ADD) & bus.M & last_k;
  assign bus.Shift_En = Reset_n & (state_q == S_SHIFT);
  assign bus.Busy     = Reset_n & ((state_q == S_CLR) | (state_q == S_ADD) |
                                   (state_q == S_SHIFT));
  assign bus.Done     = Reset_n & (state_q == S_HOLD) & first_q;

  assign bus.dbg_state = state_q;
  assign bus.dbg_k     = k_q;
endmodule

// File: tb/tb_multiplier_control.sv
module tb_multiplier_control;
  localparam int N        = 8;
  localparam int W        = 32;
  localparam int BUSY_LEN = 2 * N + 1;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiplier_control_if #(.N(N)) mc_if ();

  multiplier_control #(.N(N)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (mc_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Expected record per operation: {product[15:0], add_mask[7:0], sub_mask[7:0]}
  logic [W-1:0] exp_q[$];

  // ---------------- datapath model (closed loop) ----------------
  logic [7:0] sw_s = '0;
  logic [7:0] sw_b = '0;
  logic [7:0] dp_a = '0;
  logic [7:0] dp_b = '0;
  logic       dp_x = 1'b0;

  assign mc_if.M = dp_b[0];

  always @(posedge clk) begin
    if (mc_if.Ld_B) dp_b <= sw_b;
    if (mc_if.Clr_XA) begin
      dp_x <= 1'b0;
      dp_a <= '0;
    end
    if (mc_if.Add_En) {dp_x, dp_a} <= {dp_a[7], dp_a} + {sw_s[7], sw_s};
    if (mc_if.Sub_En) {dp_x, dp_a} <= {dp_a[7], dp_a} - {sw_s[7], sw_s};
    if (mc_if.Shift_En) {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         busy_cnt  = 0;
  int         shift_cnt = 0;
  int         stray     = 0;
  logic [7:0] add_m     = '0;
  logic [7:0] sub_m     = '0;

  initial begin : monitor
    logic [W-1:0] e;
    int           nstrobe;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0; shift_cnt = 0; stray = 0; add_m = '0; sub_m = '0;
      end else begin
        nstrobe = int'(mc_if.Add_En) + int'(mc_if.Sub_En) + int'(mc_if.Shift_En);
        check("strobe_exclusive",
              {30'd0, (nstrobe <= 1), !(mc_if.Ld_B && nstrobe != 0)}, 32'd3);
        if (mc_if.Busy) begin
          if (busy_cnt == 0 && exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_start actual=busy expected=idle");
          end
          if (mc_if.Ld_B || (mc_if.Clr_XA && busy_cnt != 0)) stray++;
          if (shift_cnt < N) begin
            if (mc_if.Add_En) add_m[shift_cnt] = 1'b1;
            if (mc_if.Sub_En) sub_m[shift_cnt] = 1'b1;
          end
          if (mc_if.Shift_En) shift_cnt++;
          busy_cnt++;
        end
        if (mc_if.Done) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=1 expected=0");
          end else begin
            e = exp_q.pop_front();
            check("product",  {16'd0, dp_a, dp_b}, {16'd0, e[31:16]});
            check("add_mask", {24'd0, add_m}, {24'd0, e[15:8]});
            check("sub_mask", {24'd0, sub_m}, {24'd0, e[7:0]});
            check("busy_len", busy_cnt, BUSY_LEN);
            check("shifts",   shift_cnt, N);
            check("stray_load_clear", stray, 0);
          end
          busy_cnt = 0; shift_cnt = 0; stray = 0; add_m = '0; sub_m = '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {mc_if.Ld_B, mc_if.Clr_XA, mc_if.Add_En, mc_if.Sub_En,
            mc_if.Shift_En, mc_if.Busy, mc_if.Done};
  endfunction

  task automatic wait_state(input logic [2:0] st, input int kk);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mc_if.dbg_state == st && int'(mc_if.dbg_k) == kk) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("wait_state_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (mc_if.Done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic load_operands(input logic [7:0] a, input logic [7:0] b);
    sw_s = a;
    sw_b = b;
    mc_if.Load_Clear = 1'b1;
    step();
    mc_if.Load_Clear = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input logic [7:0] am,
                       input logic [7:0] sm, input int hold);
    load_operands(a, b);
    exp_q.push_back({p, am, sm});
    mc_if.Run = 1'b1;
    wait_done();
    repeat (hold) step();
    mc_if.Run = 1'b0;
    repeat (2) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0]         ra, rb;
    logic signed [15:0] sa, sb, sp;

    rst_n            = 1'b0;
    mc_if.Run        = 1'b1;
    mc_if.Load_Clear = 1'b0;
    repeat (3) step();
    check("reset_outputs", {25'd0, outs()}, 32'd0);
    check("reset_state", {29'd0, mc_if.dbg_state}, {29'd0, ST_IDLE});

    // Run already high when reset releases: no start.
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("no_start_after_reset", {25'd0, outs()}, 32'd0);
    end
    mc_if.Run = 1'b0;
    step();

    // B=7, S=3: adds at k=0..2, no subtract, product 21; Run high ~25 cycles.
    do_op(8'd3, 8'd7, 16'h0015, 8'h07, 8'h00, 6);

    // B=-1, S=5: adds k=0..6, subtract at k=7, product -5.
    do_op(8'd5, 8'hFF, 16'hFFFB, 8'h7F, 8'h80, 0);

    // Load_Clear and Run toggles during ADD k=3 must be ignored.
    // S=-4, B=6, product -24.
    load_operands(8'hFC, 8'd6);
    exp_q.push_back({16'hFFE8, 8'h06, 8'h00});
    mc_if.Run = 1'b1;
    wait_state(ST_ADD, 3);
    sw_b             = 8'hA5;
    mc_if.Load_Clear = 1'b1;
    mc_if.Run        = 1'b0;
    check("no_load_while_busy", {30'd0, mc_if.Ld_B, mc_if.Clr_XA}, 32'd0);
    step();
    mc_if.Load_Clear = 1'b0;
    repeat (2) step();
    mc_if.Run = 1'b1;
    wait_done();
    mc_if.Run = 1'b0;
    repeat (2) step();

    // Run held through HOLD: exactly two operations.
    // S=-7, B=-3 -> 21, then S=2, B=-8 -> -16.
    load_operands(8'hF9, 8'hFD);
    exp_q.push_back({16'h0015, 8'h7D, 8'h80});
    mc_if.Run = 1'b1;
    wait_done();
    repeat (10) begin
      step();
      check("held_run_no_restart", {31'd0, mc_if.Busy}, 32'd0);
    end
    mc_if.Run = 1'b0;
    step();
    do_op(8'd2, 8'hF8, 16'hFFF0, 8'h78, 8'h80, 0);

    // Load in HOLD is honoured.
    load_operands(8'd1, 8'd1);
    exp_q.push_back({16'h0001, 8'h01, 8'h00});
    mc_if.Run = 1'b1;
    wait_done();
    sw_b             = 8'd3;
    mc_if.Load_Clear = 1'b1;
    #0;
    check("hold_load", {30'd0, mc_if.Ld_B, mc_if.Clr_XA}, 32'd3);
    step();
    mc_if.Load_Clear = 1'b0;
    mc_if.Run        = 1'b0;
    repeat (2) step();

    // Reset for one cycle at SHIFT k=4, Run still high.
    load_operands(8'd3, 8'd5);
    exp_q.push_back({16'h000F, 8'h05, 8'h00});
    mc_if.Run = 1'b1;
    wait_state(ST_SHIFT, 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    check("abort_outputs", {25'd0, outs()}, 32'd0);
    check("abort_state", {29'd0, mc_if.dbg_state}, {29'd0, ST_IDLE});
    repeat (5) begin
      step();
      check("abort_no_restart", {31'd0, mc_if.Busy}, 32'd0);
    end
    mc_if.Run = 1'b0;
    step();
    do_op(8'd9, 8'd10, 16'h005A, 8'h0A, 8'h00, 0);

    // Random signed pairs through the closed loop.
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sa = 16'($signed(ra));
      sb = 16'($signed(rb));
      sp = sa * sb;
      do_op(ra, rb, sp, rb & 8'h7F, rb & 8'h80, 0);
    end

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
